// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the sequential multiplier.
//   state_t  - FSM state encoding (IDLE, RUN, DONE)
//   cnt_w()  - width of the bit counter for a given operand width
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier, one multiplier bit per cycle.
// A request takes WIDTH+1 cycles from the start cycle to the done cycle.
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - request; sampled only in IDLE or DONE
//   signed_mode  - 1: a/b are two's complement, 0: unsigned (captured with start)
//   a, b         - operands (captured with start)
//   busy         - high while the shift-add loop runs
//   done         - one-cycle pulse when y has been updated
//   y            - 2*WIDTH-bit product, held until the next result
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, state_nxt;
    logic [PW-1:0]   mcand;   // multiplicand magnitude, pre-shifted by the count
    logic [WIDTH-1:0] mplier; // multiplier magnitude, LSB is the current bit
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic            neg;

    logic            accept;
    logic            last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]   acc_sum;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == LAST);

    // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
    // its magnitude when read back as unsigned.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;

    // Magnitudes are < 2^WIDTH each, so the 2*WIDTH-bit sum cannot overflow.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they align with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            y      <= '0;
        end else if (accept) begin
            mcand  <= PW'(a_mag);
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last)
                y <= neg ? -acc_sum : acc_sum;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
// Drivers push the expected product and done cycle; per-width monitors pop
// and compare whenever done is seen.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  y4;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] y8;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .y(y4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .y(y8)
    );

    typedef struct {
        logic [15:0] y;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] y;
    } vec_t;

    exp_t q4[$], q8[$];
    exp_t e4, e8;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic done4_q = 1'b0, done8_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic sm);
        longint m, sa, sb, p;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
        if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (done4) begin
            check("w4 busy low with done", 32'(busy4), 0);
            check("w4 done single-cycle", 32'(done4_q), 0);
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL w4 unexpected done: y=%0h at cycle %0d", y4, cyc);
            end else begin
                e4 = q4.pop_front();
                check("w4 product", 32'(y4), 32'(e4.y[7:0]));
                check("w4 done latency", cyc, e4.cyc);
            end
        end
        done4_q <= done4;
    end

    always @(negedge clk) begin
        if (done8) begin
            check("w8 busy low with done", 32'(busy8), 0);
            check("w8 done single-cycle", 32'(done8_q), 0);
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8 unexpected done: y=%0h at cycle %0d", y8, cyc);
            end else begin
                e8 = q8.pop_front();
                check("w8 product", 32'(y8), 32'(e8.y));
                check("w8 done latency", cyc, e8.cyc);
            end
        end
        done8_q <= done8;
    end

    // Called at a negedge with the DUT able to accept. Operands are scrambled
    // right after capture to show the in-flight operation ignores them.
    task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, input logic [15:0] exp);
        exp_t e;
        if (w == 4) begin
            start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; sm4 = sm;
        end else begin
            start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
        end
        @(posedge clk);
        #1;
        e.y = exp;
        e.cyc = cyc + w;
        if (w == 4) begin
            q4.push_back(e);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        end else begin
            q8.push_back(e);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        end
    endtask

    // Returns at the negedge of the done cycle.
    task automatic wait_done(input int w);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((w == 4) ? done4 : done8) !== 1'b1 && n < 50);
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL w%0d timeout waiting for done", w);
        end
    endtask

    vec_t v4[7] = '{
        '{8'h1, 8'h3, 1'b0, 16'h03},
        '{8'h9, 8'hB, 1'b0, 16'h63},
        '{8'hF, 8'hF, 1'b0, 16'hE1},
        '{8'h9, 8'hB, 1'b1, 16'h23},
        '{8'hD, 8'h8, 1'b1, 16'h18},
        '{8'hF, 8'h2, 1'b1, 16'hFE},
        '{8'h8, 8'h7, 1'b1, 16'hC8}
    };

    vec_t v8[4] = '{
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'h80, 8'h01, 1'b0, 16'h0080},
        '{8'hFF, 8'h7F, 1'b1, 16'hFF81}
    };

    initial begin
        logic [7:0]  ra, rb;
        logic        rs;

        #2;
        check("reset busy4", 32'(busy4), 0);
        check("reset done4", 32'(done4), 0);
        check("reset y4", 32'(y4), 0);
        check("reset y8", 32'(y8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (v4[i]) begin
            issue(4, v4[i].a, v4[i].b, v4[i].sm, v4[i].y);
            wait_done(4);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("w4 y held while idle", 32'(y4), 32'h00C8);

        // start pulsed mid-run must be dropped
        issue(4, 8'h3, 8'h5, 1'b0, 16'h0F);
        @(negedge clk);
        check("w4 busy during run", 32'(busy4), 1);
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; sm4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(4);
        repeat (8) @(negedge clk);
        check("w4 y held after ignored start", 32'(y4), 32'h000F);

        // zero operand: full length, no early exit
        issue(4, 8'h0, 8'h9, 1'b0, 16'h00);
        wait_done(4);
        @(negedge clk);

        // back-to-back: second start in the done cycle
        issue(4, 8'h6, 8'h7, 1'b0, 16'h2A);
        wait_done(4);
        issue(4, 8'hE, 8'h3, 1'b1, 16'hFA);
        wait_done(4);
        @(negedge clk);

        foreach (v8[i]) begin
            issue(8, v8[i].a, v8[i].b, v8[i].sm, v8[i].y);
            wait_done(8);
            @(negedge clk);
        end

        // reset mid-run
        issue(4, 8'h5, 8'h5, 1'b0, 16'h19);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-run reset busy4", 32'(busy4), 0);
        check("mid-run reset done4", 32'(done4), 0);
        check("mid-run reset y4", 32'(y4), 0);
        check("mid-run reset y8", 32'(y8), 0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("w4 idle after reset", 32'(busy4), 0);

        repeat (500) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            issue(4, ra, rb, rs, model(4, ra, rb, rs));
            wait_done(4);
            @(negedge clk);
        end
        repeat (500) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            issue(8, ra, rb, rs, model(8, ra, rb, rs));
            wait_done(8);
            if ($urandom_range(1, 0) == 0) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        check("w4 scoreboard drained", 32'(q4.size()), 0);
        check("w8 scoreboard drained", 32'(q8.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
